// File: rtl/digit_scroller.sv
// Ten-digit BCD message scroller: rotates the message one digit per tick (or per
// manual step while paused) and presents a registered four-digit window.
module digit_scroller #(
    parameter int TICK_DIV = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [39:0] msg_in,
    input  logic        run,
    input  logic        dir,
    input  logic        step,
    output logic [15:0] data,
    output logic [3:0]  pos,
    output logic        upd,
    output logic        wrap
);

    // state   | meaning
    // S_IDLE  | no message loaded; window held at zero
    // S_RUN   | automatic scrolling, one step per TICK_DIV cycles
    // S_PAUSE | scrolling halted; manual step pulses rotate the window
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

    state_t           state_q;
    logic [39:0]      msg_q;
    logic [15:0]      data_q;
    logic [3:0]       pos_q;
    logic [DIV_W-1:0] div_q;
    logic             upd_q;
    logic             wrap_q;

    logic [39:0]      msg_d;
    logic [3:0]       pos_d;
    logic             wrap_d;

    // Rotated message and position for a step in the current direction.
    always_comb begin
        msg_d  = msg_q;
        pos_d  = pos_q;
        wrap_d = 1'b0;
        if (dir) begin
            msg_d  = {msg_q[3:0], msg_q[39:4]};
            pos_d  = (pos_q == 4'd0) ? 4'd9 : pos_q - 4'd1;
            wrap_d = (pos_q == 4'd0);
        end else begin
            msg_d  = {msg_q[35:0], msg_q[39:36]};
            pos_d  = (pos_q == 4'd9) ? 4'd0 : pos_q + 4'd1;
            wrap_d = (pos_q == 4'd9);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            msg_q   <= '0;
            data_q  <= '0;
            pos_q   <= '0;
            div_q   <= '0;
            upd_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            upd_q  <= 1'b0;
            wrap_q <= 1'b0;
            if (load) begin
                msg_q   <= msg_in;
                data_q  <= msg_in[39:24];
                pos_q   <= '0;
                div_q   <= '0;
                upd_q   <= 1'b1;
                state_q <= run ? S_RUN : S_PAUSE;
            end else begin
                case (state_q)
                    S_RUN: begin
                        if (!run) begin
                            state_q <= S_PAUSE;
                            div_q   <= '0;
                        end else if (div_q == DIV_MAX) begin
                            div_q  <= '0;
                            msg_q  <= msg_d;
                            data_q <= msg_d[39:24];
                            pos_q  <= pos_d;
                            upd_q  <= 1'b1;
                            wrap_q <= wrap_d;
                        end else begin
                            div_q <= div_q + DIV_W'(1);
                        end
                    end
                    S_PAUSE: begin
                        // Resuming takes priority over a coincident step pulse.
                        if (run) begin
                            state_q <= S_RUN;
                            div_q   <= '0;
                        end else if (step) begin
                            msg_q  <= msg_d;
                            data_q <= msg_d[39:24];
                            pos_q  <= pos_d;
                            upd_q  <= 1'b1;
                            wrap_q <= wrap_d;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        div_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign data = data_q;
    assign pos  = pos_q;
    assign upd  = upd_q;
    assign wrap = wrap_q;

endmodule

// File: doc/digit_scroller.md
DIGIT_SCROLLER -- requirements
Module: digit_scroller

Interface
REQ-001 Parameter TICK_DIV, default 25000000, SHALL set the number of clk cycles between automatic scroll steps (legal range >= 2).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 load  input  1  single-cycle request to capture msg_in.
REQ-005 msg_in  input  40  ten-digit BCD message; digit 0 is in [39:36].
REQ-006 run  input  1  1 = automatic scrolling, 0 = paused.
REQ-007 dir  input  1  0 = scroll left, 1 = scroll right.
REQ-008 step  input  1  single-cycle manual step request, honoured only while paused.
REQ-009 data  output  16  four-digit display window, registered; it feeds the 4-digit 7-segment driver data port.
REQ-010 pos  output  4  index of the message digit currently shown leftmost, range 0..9.
REQ-011 upd  output  1  one-cycle pulse, asserted whenever data is reloaded.
REQ-012 wrap  output  1  one-cycle pulse, asserted when pos crosses the 9/0 boundary in either direction.

Function
REQ-013 The block SHALL have three states: IDLE (no message), RUN, and PAUSE.
REQ-014 A 40-bit message register msg and a divider counter div (0..TICK_DIV-1) SHALL be held internally.
REQ-015 In IDLE, data SHALL stay at 0 and step, run and divider activity SHALL be ignored.
REQ-016 Load handling: load=1 in any state SHALL, on the same edge, set msg=msg_in, data=msg_in[39:24], pos=0, div=0, upd=1 and wrap=0.
- Next state = RUN if run=1, else PAUSE.
REQ-017 In RUN, div SHALL increment by one each cycle; when div=TICK_DIV-1, div SHALL return to 0 and a step SHALL occur on that edge.
REQ-018 Left step (dir=0): msg'={msg[35:0],msg[39:36]}, pos'=(pos==9)?0:pos+1.
REQ-019 Right step (dir=1): msg'={msg[3:0],msg[39:4]}, pos'=(pos==0)?9:pos-1.
REQ-020 On every step, data SHALL equal msg'[39:24] on the same edge as the rotation, with no one-step lag, and upd SHALL be 1.
REQ-021 On every step, wrap SHALL be 1 iff pos' and pos lie on opposite sides of the 9/0 boundary.
REQ-022 dir SHALL be sampled on the edge where the step occurs; a dir change SHALL NOT reset div.
REQ-023 RUN with run=0 SHALL move to PAUSE with div cleared to 0 and no step on that edge, even if div=TICK_DIV-1.
REQ-024 PAUSE with step=1 and run=0 SHALL perform exactly one step per pulse; a step held high for N cycles SHALL yield N steps.
REQ-025 PAUSE with run=1 SHALL move to RUN with div=0, and any step on that edge SHALL be ignored.
REQ-026 upd and wrap SHALL be 0 in every cycle in which no load or step occurs.
REQ-027 Priority SHALL be rst > load > step/tick.
REQ-028 Ten consecutive same-direction steps SHALL restore msg and data to their post-load values with pos=0.

Reset
REQ-029 rst=1 SHALL, on the next edge and regardless of state or load, set state=IDLE, msg=0, data=0, pos=0, div=0, upd=0 and wrap=0.
REQ-030 Reset asserted mid-scroll SHALL discard the message; scrolling SHALL resume only after a new load.

Verification (TICK_DIV=4)
REQ-031 Reset, then run=1 for 20 cycles with no load -> data=0, pos=0, upd never asserted.
REQ-032 load with msg_in=40'h1234567890, run=1, dir=0 -> next edge data=16'h1234 and upd=1; 4 cycles later data=16'h2345, pos=1; 4 more cycles data=16'h3456, pos=2.
REQ-033 Continue to the 10th left step -> data=16'h1234, pos=0, wrap=1 on that cycle only.
REQ-034 Load same message with dir=1 -> first step data=16'h0123, pos=9, wrap=1; second step data=16'h9012, pos=8, wrap=0.
REQ-035 Drop run at div=3 -> no step, PAUSE, data unchanged for 20 cycles; one step pulse -> exactly one rotation with upd=1; run=1 together with step -> RUN, no step on that edge, next step 4 cycles later.
REQ-036 Checks at tick edges:
- load coincident with a step -> data=msg_in[39:24], pos=0.
- rst coincident with load -> IDLE with data=0.
